// File: rtl/hazard_controller.sv
// Pipeline hazard/stall sequencer: load-use, taken-branch and multi-cycle memory waits with timeout.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_reg_write_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_branch_taken_i,
    input  logic        mem_access_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        if_id_write_o,
    output logic        id_ex_write_o,
    output logic        ex_mem_write_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        mem_wb_bubble_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
);

    localparam logic [15:0] TIMEOUT_C    = 16'(MEM_TIMEOUT);
    localparam logic [15:0] TIMEOUT_M1_C = 16'(MEM_TIMEOUT - 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t      state_q;
    logic [15:0] wait_cnt_q;
    logic        mem_timeout_q;

    logic load_use;
    logic mem_stall;

    assign load_use = ex_mem_read_i & ex_reg_write_i & (ex_rd_i != 5'd0) &
                      ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    assign mem_stall = mem_access_i & ~mem_ready_i;

    // Control is purely combinational so stalls and flushes hit the same-cycle edge.
    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        id_ex_write_o   = 1'b1;
        ex_mem_write_o  = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        mem_wb_bubble_o = 1'b0;
        if (!rst_n_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
        end else if (mem_stall) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_write_o  = 1'b0;
            mem_wb_bubble_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    wait_cnt_q <= 16'd0;
                    if (mem_stall) state_q <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt_q == TIMEOUT_M1_C) mem_timeout_q <= 1'b1;
                        if (wait_cnt_q != TIMEOUT_C) wait_cnt_q <= wait_cnt_q + 16'd1;
                    end else begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= 16'd0;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    wait_cnt_q <= 16'd0;
                end
            endcase
        end
    end

    assign mem_timeout_o = mem_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (!pc_write_o)   stall_cycles_q <= stall_cycles_q + 32'd1;
            if (if_id_flush_o) flush_count_q  <= flush_count_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_count_o  = 32'd0;
`endif

endmodule
